// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 1x1 convolution layer sequencer.
// The descriptor validity rule lives here so every user applies the same check.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } seq_state_t;

  typedef struct packed {
    logic [10:0] weight_c;
    logic [10:0] num_filter;
    logic [15:0] num_pixel;
    logic [31:0] ifm_base;
    logic [31:0] wgt_base;
  } layer_desc_t;

  localparam int unsigned CH_GROUP     = 16;
  localparam int unsigned FILTER_GROUP = 4;

  function automatic logic desc_is_valid(layer_desc_t d);
    return (d.weight_c != '0) && ((d.weight_c % 11'(CH_GROUP)) == '0) &&
           (d.num_filter != '0) && ((d.num_filter % 11'(FILTER_GROUP)) == '0) &&
           (d.num_pixel != '0);
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO of layer descriptors; Depth must be a power of two so the
// pointers wrap naturally.
module desc_fifo
  import conv_seq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  layer_desc_t     wdata_i,
  input  logic            pop_i,
  output layer_desc_t     rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  layer_desc_t     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/conv1x1_layer_sequencer.sv
// Layer scheduler above the 1x1 conv controller: queues descriptors, runs them
// one at a time, relocates controller addresses and drains before each layer ends.
module conv1x1_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned DESC_DEPTH   = 4,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [10:0] desc_weight_c,
  input  logic [10:0] desc_num_filter,
  input  logic [15:0] desc_num_pixel,
  input  logic [31:0] desc_ifm_base,
  input  logic [31:0] desc_wgt_base,
  output logic        cal_start,
  output logic [10:0] weight_c,
  output logic [10:0] num_filter,
  input  logic [31:0] ctrl_addr_ifm,
  input  logic [31:0] ctrl_addr_weight,
  output logic [31:0] addr_ifm,
  output logic [31:0] addr_weight,
  input  logic        pixel_done,
  output logic        busy,
  output logic        layer_done,
  output logic        desc_err,
  output logic [15:0] layer_count
);

  localparam int unsigned CntW = $clog2(DESC_DEPTH) + 1;

  seq_state_t      state_q, state_d;
  layer_desc_t     fifo_wdata, head;
  logic            fifo_full, fifo_empty, pop, load_act;
  logic [CntW-1:0] fifo_count;
  logic [10:0]     weight_c_q, num_filter_q;
  logic [15:0]     num_pixel_q, pix_cnt_q, pix_cnt_d, layer_count_q;
  logic [31:0]     ifm_base_q, wgt_base_q, addr_ifm_q, addr_weight_q;
  logic [3:0]      drain_cnt_q, drain_cnt_d;

  assign fifo_wdata = '{weight_c: desc_weight_c, num_filter: desc_num_filter,
                        num_pixel: desc_num_pixel, ifm_base: desc_ifm_base,
                        wgt_base: desc_wgt_base};

  desc_fifo #(
    .Depth(DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (desc_valid),
    .wdata_i(fifo_wdata),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assert property (@(posedge clk) disable iff (reset)
    fifo_full |-> (fifo_count == CntW'(DESC_DEPTH)));

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pop         = 1'b0;
    load_act    = 1'b0;
    desc_err    = 1'b0;
    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = StLoad;
      StLoad: begin
        pop = 1'b1;
        if (desc_is_valid(head)) begin
          load_act  = 1'b1;
          pix_cnt_d = '0;
          state_d   = StRun;
        end else begin
          desc_err = 1'b1;
          state_d  = StIdle;
        end
      end
      StRun: begin
        if (pixel_done) begin
          pix_cnt_d = pix_cnt_q + 16'd1;
          if (pix_cnt_q == num_pixel_q - 16'd1) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == 4'(DRAIN_CYCLES - 1)) state_d = StDone;
        else drain_cnt_d = drain_cnt_q + 4'd1;
      end
      StDone:  state_d = fifo_empty ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pix_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      weight_c_q    <= '0;
      num_filter_q  <= '0;
      num_pixel_q   <= '0;
      ifm_base_q    <= '0;
      wgt_base_q    <= '0;
      addr_ifm_q    <= '0;
      addr_weight_q <= '0;
      layer_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      if (load_act) begin
        weight_c_q   <= head.weight_c;
        num_filter_q <= head.num_filter;
        num_pixel_q  <= head.num_pixel;
        ifm_base_q   <= head.ifm_base;
        wgt_base_q   <= head.wgt_base;
      end
      // Relocation is modulo 2^32; overflow wraps by design.
      addr_ifm_q    <= ifm_base_q + ctrl_addr_ifm;
      addr_weight_q <= wgt_base_q + ctrl_addr_weight;
      if (state_q == StDone) layer_count_q <= layer_count_q + 16'd1;
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign cal_start   = (state_q == StRun);
  assign busy        = (state_q != StIdle);
  assign layer_done  = (state_q == StDone);
  assign desc_ready  = !fifo_full;
  assign weight_c    = weight_c_q;
  assign num_filter  = num_filter_q;
  assign addr_ifm    = addr_ifm_q;
  assign addr_weight = addr_weight_q;
  assign layer_count = layer_count_q;

endmodule

// File: tb/tb_conv1x1_layer_sequencer.sv
// Self-checking bench: scoreboard of expected layer outcomes plus a table of
// descriptors and hand-written latency, back-pressure, drain and reset sequences.
module tb_conv1x1_layer_sequencer;
  import conv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_valid, desc_ready;
  logic [10:0] desc_weight_c, desc_num_filter;
  logic [15:0] desc_num_pixel;
  logic [31:0] desc_ifm_base, desc_wgt_base;
  logic        cal_start;
  logic [10:0] weight_c, num_filter;
  logic [31:0] ctrl_addr_ifm, ctrl_addr_weight, addr_ifm, addr_weight;
  logic        pixel_done, busy, layer_done, desc_err;
  logic [15:0] layer_count;

  always #5 clk = ~clk;

  conv1x1_layer_sequencer #(
    .DESC_DEPTH  (4),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_weight_c   (desc_weight_c),
    .desc_num_filter (desc_num_filter),
    .desc_num_pixel  (desc_num_pixel),
    .desc_ifm_base   (desc_ifm_base),
    .desc_wgt_base   (desc_wgt_base),
    .cal_start       (cal_start),
    .weight_c        (weight_c),
    .num_filter      (num_filter),
    .ctrl_addr_ifm   (ctrl_addr_ifm),
    .ctrl_addr_weight(ctrl_addr_weight),
    .addr_ifm        (addr_ifm),
    .addr_weight     (addr_weight),
    .pixel_done      (pixel_done),
    .busy            (busy),
    .layer_done      (layer_done),
    .desc_err        (desc_err),
    .layer_count     (layer_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int px_issued = 0;
  int px_gap = 1;
  logic auto_px = 1'b0;

  typedef struct {
    logic        err;
    logic [10:0] wc;
    logic [10:0] nf;
    logic [15:0] np;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [10:0] wc;
    logic [10:0] nf;
    logic [15:0] np;
    logic [31:0] ifm;
    logic [31:0] wgt;
    logic [31:0] caddr;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_err(logic [10:0] wc, logic [10:0] nf, logic [15:0] np);
    return (wc == 11'd0) || (wc[3:0] != 4'd0) || (nf == 11'd0) || (nf[1:0] != 2'd0) ||
           (np == 16'd0);
  endfunction

  // One clock: sample outputs 1 time unit after the edge, score, then drive.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (layer_done || desc_err) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got an outcome, required none pending");
      end else begin
        e = sb_q.pop_front();
        total--;
        check("sb_kind", 32'(desc_err), 32'(e.err));
        if (!e.err) begin
          check("sb_weight_c", 32'(weight_c), 32'(e.wc));
          check("sb_num_filter", 32'(num_filter), 32'(e.nf));
          check("sb_pixels", px_issued, 32'(e.np));
        end
      end
      px_issued = 0;
    end
    pixel_done = 1'b0;
    if (auto_px && cal_start && (cyc % px_gap == 0)) begin
      pixel_done = 1'b1;
      px_issued++;
    end
  endtask

  task automatic push(input logic [10:0] wc, input logic [10:0] nf, input logic [15:0] np,
                      input logic [31:0] ifm, input logic [31:0] wgt);
    exp_t e;
    int n = 0;
    desc_weight_c   = wc;
    desc_num_filter = nf;
    desc_num_pixel  = np;
    desc_ifm_base   = ifm;
    desc_wgt_base   = wgt;
    desc_valid      = 1'b1;
    while (!desc_ready && n < 300) begin
      tick();
      n++;
    end
    check("push_ready", 32'(desc_ready), 1);
    e.err = model_err(wc, nf, np);
    e.wc  = wc;
    e.nf  = nf;
    e.np  = np;
    sb_q.push_back(e);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_cal();
    int n = 0;
    while (!cal_start && n < 50) begin
      tick();
      n++;
    end
    check("wait_cal", 32'(cal_start), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_sb_empty", sb_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cal_start"}, 32'(cal_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_layer_done"}, 32'(layer_done), 0);
    check({tag, "_desc_err"}, 32'(desc_err), 0);
    check({tag, "_weight_c"}, 32'(weight_c), 0);
    check({tag, "_num_filter"}, 32'(num_filter), 0);
    check({tag, "_addr_ifm"}, addr_ifm, 0);
    check({tag, "_addr_weight"}, addr_weight, 0);
    check({tag, "_layer_count"}, 32'(layer_count), 0);
    check({tag, "_desc_ready"}, 32'(desc_ready), 1);
  endtask

  initial begin
    logic [15:0] lc0;
    int errs, dones, cals;
    logic armed, checked, saw_done, busy_acc;

    tbl[0] = '{wc: 11'd32,  nf: 11'd8,   np: 16'd3, ifm: 32'h1000, wgt: 32'h2000,
               caddr: 32'h10, exp_addr: 32'h1010, exp_err: 1'b0};
    tbl[1] = '{wc: 11'd24,  nf: 11'd8,   np: 16'd2, ifm: 32'h5000, wgt: 32'h6000,
               caddr: 32'h0, exp_addr: 32'h0, exp_err: 1'b1};
    tbl[2] = '{wc: 11'd16,  nf: 11'd4,   np: 16'd1, ifm: 32'h0, wgt: 32'h100,
               caddr: 32'h40, exp_addr: 32'h40, exp_err: 1'b0};
    tbl[3] = '{wc: 11'd48,  nf: 11'd6,   np: 16'd2, ifm: 32'h0, wgt: 32'h0,
               caddr: 32'h0, exp_addr: 32'h0, exp_err: 1'b1};
    tbl[4] = '{wc: 11'd64,  nf: 11'd12,  np: 16'd0, ifm: 32'h0, wgt: 32'h0,
               caddr: 32'h0, exp_addr: 32'h0, exp_err: 1'b1};
    tbl[5] = '{wc: 11'd0,   nf: 11'd4,   np: 16'd2, ifm: 32'h0, wgt: 32'h0,
               caddr: 32'h0, exp_addr: 32'h0, exp_err: 1'b1};
    tbl[6] = '{wc: 11'd16,  nf: 11'd4,   np: 16'd2, ifm: 32'hFFFF_FFF0, wgt: 32'h0,
               caddr: 32'h20, exp_addr: 32'h0000_0010, exp_err: 1'b0};
    tbl[7] = '{wc: 11'd2032, nf: 11'd2044, np: 16'd4, ifm: 32'h8000_0000, wgt: 32'h4000,
               caddr: 32'h7FFF_FFFF, exp_addr: 32'hFFFF_FFFF, exp_err: 1'b0};

    reset = 1'b1;
    desc_valid = 1'b0;
    desc_weight_c = '0;
    desc_num_filter = '0;
    desc_num_pixel = '0;
    desc_ifm_base = '0;
    desc_wgt_base = '0;
    ctrl_addr_ifm = '0;
    ctrl_addr_weight = '0;
    pixel_done = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check("rst_rel_busy", 32'(busy), 0);

    // Single layer: exact start, relocation and end latency.
    push(11'd32, 11'd8, 16'd3, 32'h1000, 32'h2000);
    check("t1_busy", 32'(busy), 0);
    tick();
    check("t2_busy", 32'(busy), 1);
    check("t2_cal", 32'(cal_start), 0);
    tick();
    check("t3_cal", 32'(cal_start), 1);
    check("t3_weight_c", 32'(weight_c), 32);
    check("t3_num_filter", 32'(num_filter), 8);
    ctrl_addr_ifm = 32'h10;
    ctrl_addr_weight = 32'h8;
    tick();
    check("reloc_ifm", addr_ifm, 32'h1010);
    check("reloc_wgt", addr_weight, 32'h2008);
    for (int i = 0; i < 3; i++) begin
      pixel_done = 1'b1;
      px_issued++;
      tick();
      if (i < 2) check("run_cal_held", 32'(cal_start), 1);
    end
    check("p1_cal_fall", 32'(cal_start), 0);
    check("p1_no_done", 32'(layer_done), 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("p%0d_layer_done", k), 32'(layer_done), 32'(k == 5));
    end
    tick();
    check("t1_layer_count", 32'(layer_count), 1);
    check("t1_idle", 32'(busy), 0);
    ctrl_addr_ifm = '0;
    ctrl_addr_weight = '0;

    // Table of descriptors: valid, invalid and wrapping relocation.
    auto_px = 1'b1;
    px_gap = 2;
    for (int i = 0; i < 8; i++) begin
      lc0 = layer_count;
      errs = 0;
      dones = 0;
      cals = 0;
      armed = 1'b0;
      checked = 1'b0;
      push(tbl[i].wc, tbl[i].nf, tbl[i].np, tbl[i].ifm, tbl[i].wgt);
      for (int n = 0; n < 400; n++) begin
        tick();
        if (armed && !checked) begin
          check($sformatf("tbl%0d_addr_ifm", i), addr_ifm, tbl[i].exp_addr);
          check($sformatf("tbl%0d_addr_wgt", i), addr_weight, tbl[i].wgt);
          checked = 1'b1;
        end
        if (cal_start && !armed) begin
          ctrl_addr_ifm = tbl[i].caddr;
          armed = 1'b1;
        end
        cals += int'(cal_start);
        errs += int'(desc_err);
        dones += int'(layer_done);
        if (errs != 0 || dones != 0) break;
      end
      check($sformatf("tbl%0d_err", i), errs, 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_ran", i), 32'(cals != 0), 32'(!tbl[i].exp_err));
      tick();
      check($sformatf("tbl%0d_err_once", i), 32'(desc_err), 0);
      check($sformatf("tbl%0d_count", i), 32'(layer_count),
            32'(lc0) + (tbl[i].exp_err ? 32'd0 : 32'd1));
      ctrl_addr_ifm = '0;
    end
    wait_idle();

    // Back-pressure: one layer running, four more fill the queue.
    auto_px = 1'b0;
    px_gap = 1;
    lc0 = layer_count;
    push(11'd16, 11'd4, 16'd3, 32'h0, 32'h0);
    wait_cal();
    for (int i = 0; i < 4; i++)
      push(11'(16 * (i + 2)), 11'(4 * (i + 1)), 16'd2, 32'(i), 32'(i));
    check("full_ready_low", 32'(desc_ready), 0);
    tick();
    check("full_ready_stays_low", 32'(desc_ready), 0);
    auto_px = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 100 && !desc_ready; n++) begin
      tick();
      if (layer_done) saw_done = 1'b1;
    end
    check("ready_rise", 32'(desc_ready), 1);
    check("ready_after_done", 32'(saw_done), 1);
    wait_idle();
    check("b2b_count", 32'(layer_count), 32'(lc0) + 32'd5);

    // num_pixel=1 with stray pulses in IDLE and DRAIN.
    auto_px = 1'b0;
    pixel_done = 1'b1;
    tick();
    lc0 = layer_count;
    push(11'd16, 11'd4, 16'd1, 32'h0, 32'h0);
    wait_cal();
    pixel_done = 1'b1;
    px_issued++;
    tick();
    check("np1_cal_fall", 32'(cal_start), 0);
    for (int k = 2; k <= 5; k++) begin
      pixel_done = 1'b1;
      tick();
      check($sformatf("np1_p%0d_done", k), 32'(layer_done), 32'(k == 5));
    end
    tick();
    check("np1_count", 32'(layer_count), 32'(lc0) + 32'd1);
    check("np1_idle", 32'(busy), 0);

    // Reset mid-layer with two descriptors still queued.
    push(11'd16, 11'd4, 16'd100, 32'h3000, 32'h4000);
    wait_cal();
    push(11'd32, 11'd4, 16'd2, 32'h0, 32'h0);
    push(11'd32, 11'd8, 16'd2, 32'h0, 32'h0);
    ctrl_addr_ifm = 32'h5;
    tick();
    check("pre_rst_cal", 32'(cal_start), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    px_issued = 0;
    busy_acc = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      busy_acc = busy_acc | busy;
    end
    check("post_rst_busy", 32'(busy_acc), 0);
    check("post_rst_count", 32'(layer_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
